aes_inv_cipher_iter: RTL

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

---
 rtl/aes_inv_cipher_iter.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (AES-128/192/256 selected by NK).
// A loaded key is expanded on chip one schedule word per clock; each block
// then takes one decryption round per clock, last round key first.
module aes_inv_cipher_iter #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32*NK-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [127:0]      ct_in,
    input  logic              ct_valid,
    output logic              ct_ready,
    output logic [127:0]      pt_out,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic              key_loaded,
    output logic              busy
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam int RW = $clog2(NR + 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {NOKEY, EXPAND, IDLE, ROUND, OUT} state_t;

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 in the MSBs.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (enough for 09/0b/0d/0e).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
    endfunction

    // Row r rotates right by r columns; byte 4c+r lives at [127-8(4c+r) -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_inv(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        return o;
    endfunction

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic [31:0]    r_w [NW];
    logic [IW-1:0]  r_widx;
    logic [2:0]     r_kmod;
    logic [7:0]     r_rcon;
    logic [RW-1:0]  r_round;
    logic [127:0]   r_state;
    logic [127:0]   r_pt;
    logic           r_key_loaded;

    logic           w_key_hs;
    logic           w_ct_hs;
    logic           w_last_word;
    logic           w_last_round;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_temp;
    logic [31:0]    w_new;
    logic [IW-1:0]  w_rk_base;
    logic [127:0]   w_rk;
    logic [127:0]   w_rk_last;
    logic [127:0]   w_ark;
    logic [127:0]   w_rnd;

    assign w_key_hs     = key_valid && key_ready;
    assign w_ct_hs      = ct_valid && ct_ready;
    assign w_last_word  = (r_widx == IW'(NW - 1));
    assign w_last_round = (r_round == '0);

    // Key expansion operands: the previous word and the word NK positions back.
    assign w_prev = r_w[r_widx - IW'(1)];
    assign w_back = r_w[r_widx - IW'(NK)];

    // Temp word for the schedule step; r_kmod tracks i mod NK, r_rcon tracks Rcon[i/NK].
    always_comb begin
        if (r_kmod == '0)
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
        else if (NK == 8 && r_kmod == 3'd4)
            w_temp = sub_word(w_prev);
        else
            w_temp = w_prev;
    end

    assign w_new = w_back ^ w_temp;

    // Round key r is schedule words 4r..4r+3; the first AddRoundKey uses the last one.
    assign w_rk_base = IW'({r_round, 2'b00});
    assign w_rk      = {r_w[w_rk_base], r_w[w_rk_base + IW'(1)],
                        r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};
    assign w_rk_last = {r_w[NW-4], r_w[NW-3], r_w[NW-2], r_w[NW-1]};

    // One inverse round; the final round (r == 0) skips InvMixColumns.
    assign w_ark = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk;
    assign w_rnd = w_last_round ? w_ark : inv_mix_columns(w_ark);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= NOKEY;
        else     r_fsm <= w_fsm_next;
    end

    // FSM next-state logic; a key offer in IDLE wins over a block offer.
    always_comb begin
        // NOTE: default assignment first so every path drives w_fsm_next and no latch is inferred.
        w_fsm_next = r_fsm;
        case (r_fsm)
            NOKEY:   if (key_valid) w_fsm_next = EXPAND;
            EXPAND:  if (w_last_word) w_fsm_next = IDLE;
            IDLE: begin
                if (key_valid)     w_fsm_next = EXPAND;
                else if (ct_valid) w_fsm_next = ROUND;
            end
            ROUND:   if (w_last_round) w_fsm_next = OUT;
            OUT:     if (pt_ready) w_fsm_next = IDLE;
            default: w_fsm_next = NOKEY;
        endcase
    end

    // FSM outputs, decoded from the current state.
    always_comb begin
        key_ready = (r_fsm == NOKEY) || (r_fsm == IDLE);
        ct_ready  = (r_fsm == IDLE) && !key_valid;
        pt_valid  = (r_fsm == OUT);
        busy      = (r_fsm != NOKEY) && (r_fsm != IDLE);
    end

    // Key schedule storage: key words on load, one expanded word per EXPAND cycle.
    // NOTE: no reset on this array; it is only trusted while key_loaded is high, so a reset tree buys nothing.
    always_ff @(posedge clk) begin
        if (w_key_hs) begin
            for (int k = 0; k < NK; k++) r_w[k] <= key_in[32*(NK-1-k) +: 32];
        end else if (r_fsm == EXPAND) begin
            r_w[r_widx] <= w_new;
        end
    end

    // Expansion counters, cipher state, round counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_widx       <= '0;
            r_kmod       <= '0;
            r_rcon       <= 8'h01;
            r_key_loaded <= 1'b0;
            r_round      <= '0;
            r_state      <= '0;
            r_pt         <= '0;
        end else begin
            if (w_key_hs) begin
                r_widx       <= IW'(NK);
                r_kmod       <= '0;
                r_rcon       <= 8'h01;
                r_key_loaded <= 1'b0;
            end else if (r_fsm == EXPAND) begin
                r_widx <= r_widx + IW'(1);
                r_kmod <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
                if (r_kmod == '0) r_rcon <= xtime(r_rcon);
                if (w_last_word)  r_key_loaded <= 1'b1;
            end

            if (w_ct_hs) begin
                r_state <= ct_in ^ w_rk_last;
                r_round <= RW'(NR - 1);
            end else if (r_fsm == ROUND) begin
                r_state <= w_rnd;
                if (w_last_round) r_pt    <= w_rnd;
                else              r_round <= r_round - RW'(1);
            end
        end
    end

    assign pt_out     = r_pt;
    assign key_loaded = r_key_loaded;

endmodule
